itype_lsu_fsm: RTL and testbench

- Parametrised, sequential I-type execute unit for the MIPS core.
- Executes immediate ALU ops in a single registered cycle.
- Executes word, halfword and byte loads and stores through a req/ack memory port.
- Sub-word stores are done as read-modify-write.
- Adds what the single-cycle I-type datapath lacks: halfword and unsigned variants, overflow and alignment exceptions, bus timeout, and an input/output handshake so it can stall the pipeline.

---
 rtl/itype_lsu_fsm_pkg.sv | 94 +++++++++
 rtl/itype_lsu_fsm_if.sv | 45 ++++
 rtl/itype_lsu_fsm_alu_comb.sv | 38 +++
 rtl/itype_lsu_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_itype_lsu_fsm.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/itype_lsu_fsm_pkg.sv
// Shared types and lane helpers for the I-type execute / load-store unit.
// Byte-lane numbering is big-endian: lane 0 is bits [31:24].
package itype_lsu_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [3:0] {
        OP_ADDI  = 4'd0,
        OP_ADDIU = 4'd1,
        OP_ANDI  = 4'd2,
        OP_ORI   = 4'd3,
        OP_XORI  = 4'd4,
        OP_SLTI  = 4'd5,
        OP_SLTIU = 4'd6,
        OP_LUI   = 4'd7,
        OP_LW    = 4'd8,
        OP_LH    = 4'd9,
        OP_LHU   = 4'd10,
        OP_LB    = 4'd11,
        OP_LBU   = 4'd12,
        OP_SW    = 4'd13,
        OP_SH    = 4'd14,
        OP_SB    = 4'd15
    } itype_op_e;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_OVF  = 3'd1,
        EXC_ADEL = 3'd2,
        EXC_ADES = 3'd3,
        EXC_BUS  = 3'd4
    } itype_exc_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        DONE   = 3'd5
    } lsu_state_e;

    // Pick the addressed byte/halfword out of a read word and extend it for the load op.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input itype_op_e   op);
        logic [LANE_W-1:0]   b;
        logic [2*LANE_W-1:0] h;
        logic [31:0]         r;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = lane[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  lane,
                                               input logic        half);
        logic [31:0] r;
        r = word;
        if (half) begin
            if (lane[1]) r[15:0]  = data[15:0];
            else         r[31:16] = data[15:0];
        end else begin
            case (lane)
                2'd0:    r[31:24] = data[7:0];
                2'd1:    r[23:16] = data[7:0];
                2'd2:    r[15:8]  = data[7:0];
                default: r[7:0]   = data[7:0];
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lane, input logic half);
        logic [3:0] m;
        if (half) m = lane[1] ? 4'b0011 : 4'b1100;
        else      m = 4'b1000 >> lane;
        return m;
    endfunction

endpackage

// File: rtl/itype_lsu_fsm_if.sv
// Core-side op handshake plus memory port of the I-type unit.
// ITYPE_LSU_BYTE_ENABLES_EN adds the mem_be lane mask.
interface itype_lsu_fsm_if
    import itype_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    itype_op_e         op;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [15:0]       imm;
    logic              out_valid;
    logic              reg_we;
    logic [31:0]       reg_data;
    itype_exc_e        exc_code;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
    logic [3:0]        mem_be;
`endif

    modport slave (
        input  in_valid, op, rs_data, rt_data, imm, mem_rdata, mem_ack,
        output in_ready, out_valid, reg_we, reg_data, exc_code,
               mem_req, mem_we, mem_addr, mem_wdata
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
        , output mem_be
`endif
    );

    modport master (
        output in_valid, op, rs_data, rt_data, imm, mem_rdata, mem_ack,
        input  in_ready, out_valid, reg_we, reg_data, exc_code,
               mem_req, mem_we, mem_addr, mem_wdata
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
        , input mem_be
`endif
    );
endinterface

// File: rtl/itype_lsu_fsm_alu_comb.sv
// Purely combinational immediate ALU; ovf is only meaningful for ADDI.
module itype_alu_comb
    import itype_lsu_pkg::*;
(
    input  itype_op_e   op_i,
    input  logic [31:0] rs_i,
    input  logic [15:0] imm_i,
    output logic [31:0] result_o,
    output logic        ovf_o
);
    logic [31:0] sext_s;
    logic [31:0] zext_s;
    logic [31:0] sum_s;

    assign sext_s = {{16{imm_i[15]}}, imm_i};
    assign zext_s = {16'h0000, imm_i};
    assign sum_s  = rs_i + sext_s;

    // Result mux; overflow when both addends share a sign the sum lacks.
    always_comb begin
        result_o = 32'h0;
        ovf_o    = 1'b0;
        case (op_i)
            OP_ADDI: begin
                result_o = sum_s;
                ovf_o    = (rs_i[31] == sext_s[31]) && (sum_s[31] != rs_i[31]);
            end
            OP_ADDIU: result_o = sum_s;
            OP_ANDI:  result_o = rs_i & zext_s;
            OP_ORI:   result_o = rs_i | zext_s;
            OP_XORI:  result_o = rs_i ^ zext_s;
            OP_SLTI:  result_o = ($signed(rs_i) < $signed(sext_s)) ? 32'd1 : 32'd0;
            OP_SLTIU: result_o = (rs_i < sext_s) ? 32'd1 : 32'd0;
            OP_LUI:   result_o = {imm_i, 16'h0000};
            default:  result_o = 32'h0;
        endcase
    end
endmodule

// File: rtl/itype_lsu_fsm.sv
// Sequential I-type execute unit: registered ALU ops, loads/stores over req/ack.
// ITYPE_LSU_BYTE_ENABLES_EN replaces sub-word read-modify-write with byte-enabled writes.
module itype_lsu_fsm
    import itype_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input logic           clk,
    input logic           rst,
    itype_lsu_fsm_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    lsu_state_e        state_q;
    itype_op_e         op_q;
    logic [31:0]       rt_q;
    logic [1:0]        lane_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              reg_we_q;
    logic [31:0]       reg_data_q;
    itype_exc_e        exc_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
    logic [3:0]        mem_be_q;
`endif

    logic [31:0]       alu_res_s;
    logic              alu_ovf_s;
    logic [31:0]       ea_full_s;
    logic [ADDR_W-1:0] ea_s;
    logic              is_alu_s;
    logic              is_load_s;
    logic              is_half_s;
    logic              misalign_s;
    logic              ack_s;
    logic              timeout_s;

    itype_alu_comb u_alu (
        .op_i     (bus.op),
        .rs_i     (bus.rs_data),
        .imm_i    (bus.imm),
        .result_o (alu_res_s),
        .ovf_o    (alu_ovf_s)
    );

    assign ea_full_s = bus.rs_data + {{16{bus.imm[15]}}, bus.imm};
    assign ea_s      = ea_full_s[ADDR_W-1:0];
    // An ack while no request is outstanding (e.g. the RMW gap cycle) is ignored.
    assign ack_s     = bus.mem_ack && mem_req_q;
    assign timeout_s = (TIMEOUT_CYC != 0) && (cnt_q == CNT_MAX);

    // Decode the presented op and check its alignment.
    always_comb begin
        is_alu_s   = 1'b0;
        is_load_s  = 1'b0;
        is_half_s  = 1'b0;
        misalign_s = 1'b0;
        case (bus.op)
            OP_LW:          begin is_load_s = 1'b1; misalign_s = (ea_s[1:0] != 2'b00); end
            OP_LH, OP_LHU:  begin is_load_s = 1'b1; misalign_s = ea_s[0]; end
            OP_LB, OP_LBU:  is_load_s = 1'b1;
            OP_SW:          misalign_s = (ea_s[1:0] != 2'b00);
            OP_SH:          begin is_half_s = 1'b1; misalign_s = ea_s[0]; end
            OP_SB:          is_half_s = 1'b0;
            default:        is_alu_s = 1'b1;
        endcase
    end

    // Main FSM with registered outputs and the per-request timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_ADDI;
            rt_q        <= 32'h0;
            lane_q      <= 2'b00;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_data_q  <= 32'h0;
            exc_q       <= EXC_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
            mem_be_q    <= 4'h0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        op_q       <= bus.op;
                        rt_q       <= bus.rt_data;
                        lane_q     <= ea_s[1:0];
                        cnt_q      <= '0;
                        mem_addr_q <= {ea_s[ADDR_W-1:2], 2'b00};
                        if (is_alu_s) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            if ((bus.op == OP_ADDI) && alu_ovf_s) begin
                                exc_q      <= EXC_OVF;
                                reg_we_q   <= 1'b0;
                                reg_data_q <= 32'h0;
                            end else begin
                                exc_q      <= EXC_NONE;
                                reg_we_q   <= 1'b1;
                                reg_data_q <= alu_res_s;
                            end
                        end else if (misalign_s) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            exc_q       <= is_load_s ? EXC_ADEL : EXC_ADES;
                            reg_we_q    <= 1'b0;
                            reg_data_q  <= 32'h0;
                        end else if (is_load_s) begin
                            state_q   <= RD;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
                            mem_be_q  <= 4'hF;
`endif
                        end else if (bus.op == OP_SW) begin
                            state_q     <= WR;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= bus.rt_data;
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
                            mem_be_q    <= 4'hF;
`endif
                        end else begin
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
                            state_q     <= WR;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= is_half_s ? {2{bus.rt_data[15:0]}} : {4{bus.rt_data[7:0]}};
                            mem_be_q    <= lane_mask(ea_s[1:0], is_half_s);
`else
                            state_q   <= RMW_RD;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
`endif
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RD, WR, RMW_WR: begin
                    if (!mem_req_q) begin
                        // Second half of a sub-word store after the one-cycle gap.
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                        cnt_q     <= '0;
                    end else if (ack_s || timeout_s) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        if (ack_s && (state_q == RD)) begin
                            exc_q      <= EXC_NONE;
                            reg_we_q   <= 1'b1;
                            reg_data_q <= lane_extract(bus.mem_rdata, lane_q, op_q);
                        end else begin
                            exc_q      <= ack_s ? EXC_NONE : EXC_BUS;
                            reg_we_q   <= 1'b0;
                            reg_data_q <= 32'h0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RMW_RD: begin
                    if (ack_s) begin
                        state_q     <= RMW_WR;
                        mem_req_q   <= 1'b0;
                        mem_wdata_q <= lane_merge(bus.mem_rdata, rt_q, lane_q, op_q == OP_SH);
                        cnt_q       <= '0;
                    end else if (timeout_s) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        mem_req_q   <= 1'b0;
                        exc_q       <= EXC_BUS;
                        reg_we_q    <= 1'b0;
                        reg_data_q  <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    reg_we_q    <= 1'b0;
                    reg_data_q  <= 32'h0;
                    exc_q       <= EXC_NONE;
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    mem_req_q   <= 1'b0;
                    mem_we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_data  = reg_data_q;
    assign bus.exc_code  = exc_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
    assign bus.mem_be    = mem_be_q;
`endif
endmodule

// File: tb/tb_itype_lsu_fsm.sv
// Bench for itype_lsu_fsm: table of ops against a bench-side memory responder.
module tb_itype_lsu_fsm;
    import itype_lsu_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    itype_lsu_fsm_if #(.ADDR_W(32)) bus ();

    itype_lsu_fsm #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        itype_op_e   op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [31:0] rdata;
        int          ack;    // wait cycles before ack, -1 = never
        logic        we;
        logic [31:0] data;
        itype_exc_e  exc;
        int          lat;
        int          reqc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] data;
        itype_exc_e  exc;
    } res_t;

    vec_t vt[$];
    res_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        res_t        e;
        int          lat, reqc, gap, phases, w;
        logic        prev_req, busy_rdy, done;
        logic [31:0] wd;
        logic [3:0]  be_seen;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", idx), 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = v.op;
        bus.rs_data  = v.rs;
        bus.rt_data  = v.rt;
        bus.imm      = v.imm;
        sbq.push_back('{v.we, v.data, v.exc});
        lat = 0; reqc = 0; gap = 0; phases = 0; w = 0;
        prev_req = 1'b0; busy_rdy = 1'b0; done = 1'b0; wd = 32'h0; be_seen = 4'h0;
        while (!done && lat < 40) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
            if (bus.in_ready) busy_rdy = 1'b1;
            if (bus.mem_req) begin
                if (!prev_req) begin
                    phases++;
                    if (phases == 1) chk($sformatf("v%0d_addr", idx), bus.mem_addr, v.addr);
                end
                reqc++;
                if (w == v.ack) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = v.rdata;
                    if (bus.mem_we) begin
                        wd = bus.mem_wdata;
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
                        be_seen = bus.mem_be;
`endif
                    end
                    w = 0;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 32'h0;
                    w++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                w = 0;
                if (phases == 1 && !bus.out_valid) gap++;
            end
            prev_req = bus.mem_req;
            if (bus.out_valid) begin
                done = 1'b1;
                e = sbq.pop_front();
                chk($sformatf("v%0d_reg_we", idx), 32'(bus.reg_we), 32'(e.we));
                chk($sformatf("v%0d_reg_data", idx), bus.reg_data, e.data);
                chk($sformatf("v%0d_exc", idx), 32'(bus.exc_code), 32'(e.exc));
                chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d_no_completion: got none expected out_valid within 40 cycles", idx);
            void'(sbq.pop_front());
        end
        bus.mem_ack = 1'b0;
        chk($sformatf("v%0d_req_cycles", idx), 32'(reqc), 32'(v.reqc));
        chk($sformatf("v%0d_busy_ready", idx), 32'(busy_rdy), 32'd0);
        if (v.op inside {OP_SW, OP_SH, OP_SB} && v.exc == EXC_NONE) begin
            chk($sformatf("v%0d_wdata", idx), wd, v.wdata);
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
            chk($sformatf("v%0d_be", idx), 32'(be_seen), 32'(v.be));
`endif
        end
        if (phases == 2) chk($sformatf("v%0d_rmw_gap", idx), 32'(gap), 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d_pulse", idx), 32'(bus.out_valid), 32'd0);
        chk($sformatf("v%0d_back_idle", idx), 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADDI;
        bus.rs_data   = 32'h0;
        bus.rt_data   = 32'h0;
        bus.imm       = 16'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b0;

        //              op        rs            rt            imm       rdata         ack we    data          exc       lat reqc addr          wdata         be
        vt.push_back('{OP_ADDI,  32'h7FFFFFFF, 32'h0,        16'h0001, 32'h0,        0,  1'b0, 32'h0,        EXC_OVF,  1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_ADDIU, 32'h7FFFFFFF, 32'h0,        16'h0001, 32'h0,        0,  1'b1, 32'h80000000, EXC_NONE, 1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_SLTI,  32'hFFFFFFFF, 32'h0,        16'h0000, 32'h0,        0,  1'b1, 32'h1,        EXC_NONE, 1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_SLTIU, 32'hFFFFFFFF, 32'h0,        16'h0000, 32'h0,        0,  1'b1, 32'h0,        EXC_NONE, 1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_ANDI,  32'h12345678, 32'h0,        16'hF0F0, 32'h0,        0,  1'b1, 32'h00005070, EXC_NONE, 1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_ORI,   32'h12340000, 32'h0,        16'h8001, 32'h0,        0,  1'b1, 32'h12348001, EXC_NONE, 1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_XORI,  32'hFFFF0000, 32'h0,        16'hFFFF, 32'h0,        0,  1'b1, 32'hFFFFFFFF, EXC_NONE, 1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_LUI,   32'h0,        32'h0,        16'hABCD, 32'h0,        0,  1'b1, 32'hABCD0000, EXC_NONE, 1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_SLTI,  32'h80000000, 32'h0,        16'h0001, 32'h0,        0,  1'b1, 32'h1,        EXC_NONE, 1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_ADDI,  32'h80000000, 32'h0,        16'hFFFF, 32'h0,        0,  1'b0, 32'h0,        EXC_OVF,  1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_LB,    32'h00001000, 32'h0,        16'h0001, 32'h11A23344, 3,  1'b1, 32'hFFFFFFA2, EXC_NONE, 5, 4, 32'h1000,     32'h0,        4'h0});
        vt.push_back('{OP_LBU,   32'h00001000, 32'h0,        16'h0001, 32'h11A23344, 3,  1'b1, 32'h000000A2, EXC_NONE, 5, 4, 32'h1000,     32'h0,        4'h0});
        vt.push_back('{OP_LH,    32'h00001000, 32'h0,        16'h0002, 32'h11A2B344, 0,  1'b1, 32'hFFFFB344, EXC_NONE, 2, 1, 32'h1000,     32'h0,        4'h0});
        vt.push_back('{OP_LHU,   32'h00001000, 32'h0,        16'h0002, 32'h11A2B344, 0,  1'b1, 32'h0000B344, EXC_NONE, 2, 1, 32'h1000,     32'h0,        4'h0});
        vt.push_back('{OP_LW,    32'h00001004, 32'h0,        16'hFFFC, 32'hDEADBEEF, 1,  1'b1, 32'hDEADBEEF, EXC_NONE, 3, 2, 32'h1000,     32'h0,        4'h0});
`ifdef ITYPE_LSU_BYTE_ENABLES_EN
        vt.push_back('{OP_SB,    32'h00002000, 32'h000000EE, 16'h0003, 32'h01020304, 0,  1'b0, 32'h0,        EXC_NONE, 2, 1, 32'h2000,     32'hEEEEEEEE, 4'b0001});
        vt.push_back('{OP_SH,    32'h00002000, 32'h0000CAFE, 16'h0000, 32'h01020304, 1,  1'b0, 32'h0,        EXC_NONE, 3, 2, 32'h2000,     32'hCAFECAFE, 4'b1100});
`else
        vt.push_back('{OP_SB,    32'h00002000, 32'h000000EE, 16'h0003, 32'h01020304, 0,  1'b0, 32'h0,        EXC_NONE, 4, 2, 32'h2000,     32'h010203EE, 4'h0});
        vt.push_back('{OP_SH,    32'h00002000, 32'h0000CAFE, 16'h0000, 32'h01020304, 1,  1'b0, 32'h0,        EXC_NONE, 6, 4, 32'h2000,     32'hCAFE0304, 4'h0});
`endif
        vt.push_back('{OP_SW,    32'h00002008, 32'h12345678, 16'h0000, 32'h0,        2,  1'b0, 32'h0,        EXC_NONE, 4, 3, 32'h2008,     32'h12345678, 4'hF});
        vt.push_back('{OP_LH,    32'h00003000, 32'h0,        16'h0001, 32'h0,        0,  1'b0, 32'h0,        EXC_ADEL, 1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_SW,    32'h00003000, 32'h0,        16'h0002, 32'h0,        0,  1'b0, 32'h0,        EXC_ADES, 1, 0, 32'h0,        32'h0,        4'h0});
        vt.push_back('{OP_LW,    32'h00004000, 32'h0,        16'h0000, 32'h0,        -1, 1'b0, 32'h0,        EXC_BUS,  5, 4, 32'h4000,     32'h0,        4'h0});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_reg_we",    32'(bus.reg_we),    32'd0);
        chk("rst_reg_data",  bus.reg_data,       32'h0);
        chk("rst_exc",       32'(bus.exc_code),  32'd0);
        chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  bus.mem_addr,       32'h0);
        chk("rst_mem_wdata", bus.mem_wdata,      32'h0);

        for (int i = 0; i < vt.size(); i++) run_vec(i, vt[i]);

        // Stray ack while idle must not produce a completion.
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFFFFFF;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid || bus.mem_req) seen = 1'b1;
        end
        bus.mem_ack = 1'b0;
        chk("stray_ack_ignored", 32'(seen), 32'd0);

        // Reset in the middle of a load.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = OP_LW;
        bus.rs_data  = 32'h00005000;
        bus.imm      = 16'h0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("midrd_req_high", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrd_req_drop", 32'(bus.mem_req),   32'd0);
        chk("midrd_in_ready", 32'(bus.in_ready),  32'd1);
        chk("midrd_no_valid", 32'(bus.out_valid), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid || bus.mem_req) seen = 1'b1;
        end
        chk("midrd_discarded", 32'(seen), 32'd0);

        // Unit still works after the mid-access reset.
        run_vec(100, '{OP_ADDIU, 32'h00000010, 32'h0, 16'hFFFF, 32'h0, 0, 1'b1, 32'h0000000F, EXC_NONE, 1, 0, 32'h0, 32'h0, 4'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
